// File: rtl/apf_keypad_scan.sv
// APF MP1000 hand-controller input stage: maps PS/2 key events and joystick bits onto the two
// 4x4 keypad matrices and answers the PIA column scan with registered active-low row data.
module apf_keypad_scan #(
  parameter int HOLD_CYCLES = 400000,
  parameter int HOLD_W      = 19
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic [10:0] ps2_key,
  input  logic [4:0]  joy0,
  input  logic [4:0]  joy1,
  input  logic [3:0]  pia_col_n,
  output logic [7:0]  key_rows_n,
  output logic [1:0]  fire_n,
  output logic        key_any
);

  // Key slots: 0..15 player-1 matrix (col*4+row), 16..31 player-2 matrix, 32 player-1 fire.
  localparam int                NKEYS     = 33;
  localparam int                FIRE_IDX  = 32;
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES);
  localparam logic [HOLD_W-1:0] CNT_ONE   = HOLD_W'(1);

  logic              old_stb_q;
  logic              ev;
  logic              map_vld;
  logic [5:0]        map_idx;
  logic [NKEYS-1:0]  held_q, held_d;
  logic [NKEYS-1:0]  pend_q, pend_d;
  logic [HOLD_W-1:0] cnt_q [NKEYS];
  logic [HOLD_W-1:0] cnt_d [NKEYS];
  logic [15:0]       p1_prs, p2_prs;
  logic [7:0]        rows_q, rows_d;
  logic [1:0]        fire_q, fire_d;
  logic              key_any_q;

  assign ev = ps2_key[10] ^ old_stb_q;

  // The extended bit is part of the key: 6B/72/74/75 are P2 digits plain, P1 arrows with E0.
  always_comb begin
    map_vld = 1'b1;
    map_idx = 6'd0;
    case ({ps2_key[8], ps2_key[7:0]})
      9'h016: map_idx = 6'd0;
      9'h01E: map_idx = 6'd1;
      9'h026: map_idx = 6'd2;
      9'h025: map_idx = 6'd4;
      9'h02E: map_idx = 6'd5;
      9'h036: map_idx = 6'd6;
      9'h03D: map_idx = 6'd8;
      9'h03E: map_idx = 6'd9;
      9'h046: map_idx = 6'd10;
      9'h021: map_idx = 6'd12;
      9'h045: map_idx = 6'd13;
      9'h05A: map_idx = 6'd14;
      9'h029: map_idx = 6'(FIRE_IDX);
      9'h175: map_idx = 6'd3;
      9'h172: map_idx = 6'd7;
      9'h16B: map_idx = 6'd11;
      9'h174: map_idx = 6'd15;
      9'h069: map_idx = 6'd16;
      9'h072: map_idx = 6'd17;
      9'h07A: map_idx = 6'd18;
      9'h06B: map_idx = 6'd20;
      9'h073: map_idx = 6'd21;
      9'h074: map_idx = 6'd22;
      9'h06C: map_idx = 6'd24;
      9'h075: map_idx = 6'd25;
      9'h07D: map_idx = 6'd26;
      9'h07B: map_idx = 6'd28;
      9'h070: map_idx = 6'd29;
      9'h079: map_idx = 6'd30;
      default: map_vld = 1'b0;
    endcase
  end

  always_comb begin
    held_d = held_q;
    pend_d = pend_q;
    for (int k = 0; k < NKEYS; k++) begin
      cnt_d[k] = cnt_q[k];
      if (cnt_q[k] != '0) begin
        cnt_d[k] = cnt_q[k] - CNT_ONE;
        if (cnt_q[k] == CNT_ONE && pend_q[k]) begin
          held_d[k] = 1'b0;
          pend_d[k] = 1'b0;
        end
      end
    end
    // A release landing on the final hold cycle ends the key now rather than leaving pend set.
    if (ev && map_vld) begin
      if (ps2_key[9]) begin
        held_d[map_idx] = 1'b1;
        pend_d[map_idx] = 1'b0;
        cnt_d[map_idx]  = HOLD_LOAD;
      end else if (cnt_q[map_idx] > CNT_ONE) begin
        pend_d[map_idx] = 1'b1;
      end else begin
        held_d[map_idx] = 1'b0;
        pend_d[map_idx] = 1'b0;
      end
    end
  end

  always_comb begin
    p1_prs     = held_q[15:0];
    p2_prs     = held_q[31:16];
    p1_prs[3]  = held_q[3]  | joy0[3];
    p1_prs[7]  = held_q[7]  | joy0[2];
    p1_prs[11] = held_q[11] | joy0[1];
    p1_prs[15] = held_q[15] | joy0[0];
    p2_prs[3]  = held_q[19] | joy1[3];
    p2_prs[7]  = held_q[23] | joy1[2];
    p2_prs[11] = held_q[27] | joy1[1];
    p2_prs[15] = held_q[31] | joy1[0];
    rows_d = 8'hFF;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        if (!pia_col_n[c]) begin
          if (p1_prs[c*4+r]) rows_d[r]   = 1'b0;
          if (p2_prs[c*4+r]) rows_d[4+r] = 1'b0;
        end
      end
    end
    fire_d = {~joy1[4], ~(held_q[FIRE_IDX] | joy0[4])};
  end

  always_ff @(posedge clk_sys) begin
    old_stb_q <= ps2_key[10];
    if (reset) begin
      held_q    <= '0;
      pend_q    <= '0;
      for (int k = 0; k < NKEYS; k++) cnt_q[k] <= '0;
      rows_q    <= 8'hFF;
      fire_q    <= 2'b11;
      key_any_q <= 1'b0;
    end else begin
      held_q    <= held_d;
      pend_q    <= pend_d;
      for (int k = 0; k < NKEYS; k++) cnt_q[k] <= cnt_d[k];
      rows_q    <= rows_d;
      fire_q    <= fire_d;
      key_any_q <= ev & map_vld & ps2_key[9];
    end
  end

  assign key_rows_n = rows_q;
  assign fire_n     = fire_q;
  assign key_any    = key_any_q;

endmodule
